// File: rtl/reg_pkg.sv
// Shared register-bus types for reg_file_responder and its byte-merge helper.
// Request/response structs plus the responder state encoding.
package reg_pkg;

  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int StrbWidth = DataWidth / 8;
  localparam int RegIdxLsb = 2;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef struct packed {
    addr_t addr;
    logic  write;
    data_t wdata;
    strb_t wstrb;
    logic  valid;
  } reg_req_t;

  typedef struct packed {
    data_t rdata;
    logic  error;
    logic  ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } reg_resp_state_e;

  // Expands a byte strobe into a per-bit data mask.
  function automatic data_t strb_to_mask(input strb_t strb);
    data_t mask;
    for (int b = 0; b < StrbWidth; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/reg_strb_merge.sv
// Next-value computation for one register: hardware load of the full word,
// overlaid by the strobed bytes of a committing bus write.
module reg_strb_merge
  import reg_pkg::*;
(
  input  data_t i_q,
  input  logic  i_bus_we,
  input  data_t i_bus_wdata,
  input  strb_t i_bus_strb,
  input  logic  i_hw_we,
  input  data_t i_hw_wdata,
  output data_t o_d
);

  data_t w_base;
  data_t w_mask;

  // Bus bytes win over hardware bytes, which win over the held value.
  always_comb begin
    w_base = i_hw_we  ? i_hw_wdata : i_q;
    w_mask = i_bus_we ? strb_to_mask(i_bus_strb) : {DataWidth{1'b0}};
    o_d    = (i_bus_wdata & w_mask) | (w_base & ~w_mask);
  end

endmodule

// File: rtl/reg_file_responder.sv
// Register-bus responder: a bank of NumRegs 32-bit registers with byte-strobed
// bus writes, hardware load ports and a configurable number of wait states.
module reg_file_responder
  import reg_pkg::*;
#(
  parameter int    NumRegs    = 16,
  parameter int    Latency    = 1,
  parameter data_t ResetValue = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  reg_req_t                  reg_req_i,
  output reg_rsp_t                  reg_rsp_o,
  output data_t [NumRegs-1:0]       reg_q_o,
  output logic  [NumRegs-1:0]       sw_wr_o,
  input  logic  [NumRegs-1:0]       hw_we_i,
  input  data_t [NumRegs-1:0]       hw_wdata_i
);

  localparam int IdxWidth = AddrWidth - RegIdxLsb;
  typedef logic [IdxWidth-1:0] idx_t;

  localparam idx_t       NumRegsIdx = idx_t'(NumRegs);
  localparam logic [3:0] LatCnt     = (Latency > 0) ? 4'(Latency - 1) : 4'd0;
  localparam data_t      DataZero   = {DataWidth{1'b0}};

  reg_resp_state_e r_state;
  logic [3:0]      r_cnt;
  logic            r_from_resp;
  addr_t           r_addr;
  logic            r_write;
  data_t           r_wdata;
  strb_t           r_wstrb;

  data_t [NumRegs-1:0] r_q;
  logic  [NumRegs-1:0] r_sw_wr;

  addr_t               w_addr;
  logic                w_write;
  data_t               w_wdata;
  strb_t               w_wstrb;
  logic                w_ready;
  idx_t                w_idx;
  logic                w_err;
  logic                w_commit;
  data_t               w_rdata_sel;
  logic  [NumRegs-1:0] w_bus_we;
  data_t [NumRegs-1:0] w_q_next;

  // With zero latency the live request is decoded; otherwise the captured copy.
  always_comb begin
    if (Latency == 0) begin
      w_addr  = reg_req_i.addr;
      w_write = reg_req_i.write;
      w_wdata = reg_req_i.wdata;
      w_wstrb = reg_req_i.wstrb;
      w_ready = reg_req_i.valid & ~rst_i;
    end else begin
      w_addr  = r_addr;
      w_write = r_write;
      w_wdata = r_wdata;
      w_wstrb = r_wstrb;
      w_ready = (r_state == RESP) & ~rst_i;
    end
  end

  // Address decode, commit qualification and read mux.
  always_comb begin
    w_idx       = w_addr[AddrWidth-1:RegIdxLsb];
    w_err       = (w_addr[RegIdxLsb-1:0] != 2'b00) | (w_idx >= NumRegsIdx);
    w_commit    = w_ready & w_write & ~w_err & (|w_wstrb);
    w_rdata_sel = DataZero;
    for (int i = 0; i < NumRegs; i++) begin
      w_bus_we[i] = w_commit & (w_idx == idx_t'(i));
      w_rdata_sel = w_rdata_sel | ((w_idx == idx_t'(i)) ? r_q[i] : DataZero);
    end
  end

  // Response is zero everywhere except in the ready cycle.
  always_comb begin
    reg_rsp_o.ready = w_ready;
    reg_rsp_o.error = w_ready & w_err;
    reg_rsp_o.rdata = (w_ready & ~w_err) ? w_rdata_sel : DataZero;
  end

  for (genvar g = 0; g < NumRegs; g++) begin : g_reg
    reg_strb_merge u_merge (
      .i_q        (r_q[g]),
      .i_bus_we   (w_bus_we[g]),
      .i_bus_wdata(w_wdata),
      .i_bus_strb (w_wstrb),
      .i_hw_we    (hw_we_i[g]),
      .i_hw_wdata (hw_wdata_i[g]),
      .o_d        (w_q_next[g])
    );
  end

  // Register bank and write-notification pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q     <= {NumRegs{ResetValue}};
      r_sw_wr <= {NumRegs{1'b0}};
    end else begin
      r_q     <= w_q_next;
      r_sw_wr <= w_bus_we;
    end
  end

  // Wait-state FSM; r_from_resp blocks acceptance in the cycle after RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_from_resp <= 1'b0;
      r_addr      <= {AddrWidth{1'b0}};
      r_write     <= 1'b0;
      r_wdata     <= DataZero;
      r_wstrb     <= {StrbWidth{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_from_resp <= 1'b0;
          if ((Latency != 0) && reg_req_i.valid && !r_from_resp) begin
            r_addr  <= reg_req_i.addr;
            r_write <= reg_req_i.write;
            r_wdata <= reg_req_i.wdata;
            r_wstrb <= reg_req_i.wstrb;
            r_cnt   <= LatCnt;
            r_state <= (Latency == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!reg_req_i.valid) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else begin
            // The counter reaches zero on this edge, so the next cycle responds.
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_from_resp <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= 4'd0;
          r_from_resp <= 1'b0;
        end
      endcase
    end
  end

  assign reg_q_o = r_q;
  assign sw_wr_o = r_sw_wr;

endmodule

// File: tb/tb_reg_file_responder.sv
// Bench for reg_file_responder: three instances (Latency 1, 4, 0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_reg_file_responder;
  import reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_req_t          req   [3];
  reg_rsp_t          rsp   [3];
  data_t [15:0]      rq    [3];
  logic  [15:0]      sw    [3];
  logic  [15:0]      hw_we [3];
  data_t [15:0]      hw_wd [3];

  int lat [3] = '{1, 4, 0};

  reg_file_responder #(.NumRegs(16), .Latency(1), .ResetValue(32'h0)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req[0]), .reg_rsp_o(rsp[0]),
    .reg_q_o(rq[0]), .sw_wr_o(sw[0]), .hw_we_i(hw_we[0]), .hw_wdata_i(hw_wd[0]));
  reg_file_responder #(.NumRegs(16), .Latency(4), .ResetValue(32'h0)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req[1]), .reg_rsp_o(rsp[1]),
    .reg_q_o(rq[1]), .sw_wr_o(sw[1]), .hw_we_i(hw_we[1]), .hw_wdata_i(hw_wd[1]));
  reg_file_responder #(.NumRegs(16), .Latency(0), .ResetValue(32'h0)) u_dut_l0 (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req[2]), .reg_rsp_o(rsp[2]),
    .reg_q_o(rq[2]), .sw_wr_o(sw[2]), .hw_we_i(hw_we[2]), .hw_wdata_i(hw_wd[2]));

  int n_chk  = 0;
  int n_pass = 0;
  int sw0_pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: registers, pending transaction age, cooldown.
  data_t       mq     [3][16];
  logic [15:0] m_sw   [3];
  bit          m_busy [3];
  bit          m_cool [3];
  int          m_age  [3];
  addr_t       m_addr [3];
  logic        m_wr   [3];
  data_t       m_wd   [3];
  strb_t       m_st   [3];
  bit          m_on = 1'b0;

  initial begin
    logic rdy, bad, cm, w;
    addr_t a;
    data_t d;
    strb_t s;
    int ix;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0) begin
          a = req[k].addr; w = req[k].write; d = req[k].wdata; s = req[k].wstrb;
          rdy = req[k].valid && !rst;
        end else begin
          a = m_addr[k]; w = m_wr[k]; d = m_wd[k]; s = m_st[k];
          rdy = m_busy[k] && (m_age[k] == lat[k]) && !rst;
        end
        bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd16);
        ix  = int'(a[5:2]);
        if (m_on) begin
          chk($sformatf("ready[%0d]", k), 32'(rsp[k].ready), 32'(rdy));
          chk($sformatf("error[%0d]", k), 32'(rsp[k].error), 32'(rdy && bad));
          chk($sformatf("rdata[%0d]", k), rsp[k].rdata, (rdy && !bad) ? mq[k][ix] : 32'h0);
          chk($sformatf("sw_wr[%0d]", k), 32'(sw[k]), 32'(m_sw[k]));
          for (int i = 0; i < 16; i++) chk($sformatf("reg_q[%0d][%0d]", k, i), rq[k][i], mq[k][i]);
          if (k == 0) sw0_pulses += $countones(sw[0]);
        end
        if (rst) begin
          for (int i = 0; i < 16; i++) mq[k][i] = 32'h0;
          m_sw[k] = 16'h0; m_busy[k] = 1'b0; m_cool[k] = 1'b0; m_age[k] = 0;
          m_addr[k] = 32'h0; m_wr[k] = 1'b0; m_wd[k] = 32'h0; m_st[k] = 4'h0;
        end else begin
          cm = rdy && w && !bad && (s != 4'h0);
          for (int i = 0; i < 16; i++) if (hw_we[k][i]) mq[k][i] = hw_wd[k][i];
          if (cm) for (int b = 0; b < 4; b++) if (s[b]) mq[k][ix][8*b +: 8] = d[8*b +: 8];
          m_sw[k] = cm ? (16'h1 << ix) : 16'h0;
          if (lat[k] != 0) begin
            if (m_busy[k]) begin
              if (m_age[k] == lat[k]) begin m_busy[k] = 1'b0; m_cool[k] = 1'b1; end
              else if (!req[k].valid) m_busy[k] = 1'b0;
              else m_age[k]++;
            end else if (m_cool[k]) begin
              m_cool[k] = 1'b0;
            end else if (req[k].valid) begin
              m_busy[k] = 1'b1; m_age[k] = 1;
              m_addr[k] = req[k].addr; m_wr[k] = req[k].write;
              m_wd[k] = req[k].wdata; m_st[k] = req[k].wstrb;
            end
          end
        end
      end
      if (rst) m_on = 1'b1;
    end
  end

  task automatic bus_txn(input int k, input addr_t a, input logic w, input data_t d,
                         input strb_t s, output data_t rd, output logic er, output int cyc);
    @(posedge clk); #1;
    req[k] = '{addr: a, write: w, wdata: d, wstrb: s, valid: 1'b1};
    cyc = 0; rd = 32'h0; er = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp[k].ready) begin rd = rsp[k].rdata; er = rsp[k].error; break; end
      cyc++;
      if (cyc > 40) begin chk("txn_timeout", 32'd1, 32'd0); break; end
    end
    @(posedge clk); #1;
    req[k].valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    data_t rd;
    logic  er;
    int    cyc;
    int    seen;
    for (int k = 0; k < 3; k++) begin
      req[k] = '{addr: 32'h0, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b0};
      hw_we[k] = 16'h0;
      for (int i = 0; i < 16; i++) hw_wd[k][i] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then read.
    bus_txn(0, 32'h0, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t1_latency", 32'(cyc), 32'd1);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_error", 32'(er), 32'd0);

    // Strobed write and readback.
    bus_txn(0, 32'h8, 1'b1, 32'hDEADBEEF, 4'b0101, rd, er, cyc);
    bus_txn(0, 32'h8, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t2_rdata", rd, 32'h00AD00EF);
    chk("t2_pulses", 32'(sw0_pulses), 32'd1);

    // Decode errors.
    bus_txn(0, 32'h41, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    chk("t3_mis_error", 32'(er), 32'd1);
    chk("t3_mis_rdata", rd, 32'h0);
    bus_txn(0, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    chk("t3_oob_error", 32'(er), 32'd1);
    chk("t3_oob_rdata", rd, 32'h0);
    chk("t3_pulses", 32'(sw0_pulses), 32'd1);

    // Bus and hardware write collision on register 3.
    hw_we[0][3] = 1'b1; hw_wd[0][3] = 32'h12345678;
    bus_txn(0, 32'hC, 1'b1, 32'hFFFFFFFF, 4'b0011, rd, er, cyc);
    hw_we[0][3] = 1'b0;
    chk("t4_reg_q", rq[0][3], 32'h1234FFFF);
    bus_txn(0, 32'hC, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t4_rdata", rd, 32'h1234FFFF);

    // Latency 4: wait-state length.
    bus_txn(1, 32'h10, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
    chk("t5_latency", 32'(cyc), 32'd4);
    bus_txn(1, 32'h10, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t5_rdata", rd, 32'hA5A5A5A5);

    // Abort: valid drops in cycle 2.
    seen = 0;
    @(posedge clk); #1;
    req[1] = '{addr: 32'h14, write: 1'b1, wdata: 32'h11111111, wstrb: 4'hF, valid: 1'b1};
    repeat (2) begin
      @(negedge clk); if (rsp[1].ready) seen++;
      @(posedge clk); #1;
    end
    req[1].valid = 1'b0;
    repeat (8) begin @(negedge clk); if (rsp[1].ready) seen++; end
    chk("t5_abort_ready", 32'(seen), 32'd0);
    bus_txn(1, 32'h14, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t5_abort_rdata", rd, 32'h0);

    // Reset in cycle 3 of a write.
    seen = 0;
    @(posedge clk); #1;
    req[1] = '{addr: 32'h18, write: 1'b1, wdata: 32'h22222222, wstrb: 4'hF, valid: 1'b1};
    repeat (3) begin
      @(negedge clk); if (rsp[1].ready) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); if (rsp[1].ready) seen++;
    @(posedge clk); #1;
    rst = 1'b0; req[1].valid = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp[1].ready) seen++; end
    chk("t5_rst_ready", 32'(seen), 32'd0);
    chk("t5_rst_reg_q", rq[1][6], 32'h0);
    bus_txn(1, 32'h18, 1'b0, 32'h0, 4'h0, rd, er, cyc);
    chk("t5_rst_rdata", rd, 32'h0);

    // Zero latency back-to-back writes then reads.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req[2] = '{addr: 32'(i * 4), write: 1'b1, wdata: 32'(16 + i), wstrb: 4'hF, valid: 1'b1};
      @(negedge clk);
      chk($sformatf("t6_wr_ready%0d", i), 32'(rsp[2].ready), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req[2] = '{addr: 32'(i * 4), write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
      @(negedge clk);
      chk($sformatf("t6_rd_ready%0d", i), 32'(rsp[2].ready), 32'd1);
      chk($sformatf("t6_rdata%0d", i), rsp[2].rdata, 32'(16 + i));
    end
    @(posedge clk); #1;
    req[2].valid = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
